axi_imem_rd_responder: RTL and testbench
========================================

Name: axi_imem_rd_responder

Overview:
AXI4 read-only responder that models the instruction memory behind the icache. It accepts read-address bursts on the AR channel and returns full-width beats on the R channel from an internal line-wide RAM. A simple write port preloads program images for simulation and boot. It sits at the far end of the icache refill interface, or behind the interconnect.

Parameters:
C_AXI_ID_WIDTH, 10, AR/R ID width.
C_AXI_ADDR_WIDTH, 32, byte address width.
C_AXI_DATA_WIDTH, 512, beat width in bits; one beat is one RAM word.
MEM_DEPTH, 1024, number of RAM words (power of 2).
BASE_ADDR, 32'h0, byte address of RAM word 0.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
axi_arvalid  in  1  read address valid
axi_arready  out  1  read address ready
axi_arid  in  C_AXI_ID_WIDTH  request ID
axi_araddr  in  C_AXI_ADDR_WIDTH  start byte address
axi_arlen  in  8  beats minus 1
axi_arsize  in  3  beat size code
axi_arburst  in  2  burst type
axi_arlock/arcache/arprot  in  1/4/3  accepted and ignored
axi_rvalid  out  1  read data valid
axi_rready  in  1  read data ready
axi_rid  out  C_AXI_ID_WIDTH  echoed arid
axi_rdata  out  C_AXI_DATA_WIDTH  beat data
axi_rresp  out  2  2'b00 OKAY, 2'b10 SLVERR
axi_rlast  out  1  final beat of burst
ld_we  in  1  preload write enable
ld_addr  in  $clog2(MEM_DEPTH)  preload word index
ld_data  in  C_AXI_DATA_WIDTH  preload data

Behaviour:
- Reset (async assert, sync deassert): state IDLE; arready=0 during reset and 1 in the first cycle after; rvalid=0, rlast=0, rresp=0, rid=0, rdata=0; beat counter and skid buffer are cleared. RAM contents are not reset.
- Only one burst is outstanding at a time. FSM states:
  - IDLE: arready=1. When arvalid&arready, latch id, the word address ((araddr-BASE_ADDR)>>log2(DATA_W/8)), len, and the error flag. Go to BURST.
  - BURST: arready=0. Issue RAM reads. Go to DRAIN after the read for beat len is issued.
  - DRAIN: wait until the final beat handshakes (rvalid&rready&rlast), then go to IDLE. arready returns to 1 in the cycle after the last handshake.
- RAM read latency is 1 cycle. A 2-entry skid buffer holds {data, resp, last}.
  - A read is issued only when the entries in flight plus those occupied are below 2.
  - Full throughput: with rready held at 1, beats arrive back-to-back.
  - Latency: AR handshake at cycle T gives the first rvalid at T+2.
- R channel rules: once rvalid=1, rdata, rresp, rlast and rid stay stable until rready=1. rvalid never depends combinationally on rready.
- Burst address:
  - INCR: word index increments by 1 per beat.
  - WRAP: legal only for len in {1,3,7,15}; the index wraps within an aligned (len+1)-word block.
  - FIXED, reserved burst type, or illegal WRAP len: every beat returns SLVERR with data 0.
- arsize != log2(C_AXI_DATA_WIDTH/8): SLVERR on all beats. The full len+1 beats are always returned, with rlast on the last.
- Range check:
  - A beat whose word index is >= MEM_DEPTH, or whose araddr is < BASE_ADDR, returns SLVERR with data 0.
  - In-range beats of the same burst return OKAY.
  - The 4 KB boundary is not checked.
- Unaligned araddr: the low bits are ignored (the address is truncated to its word).
- Preload:
  - ld_we writes ld_data at ld_addr on the clock edge and has priority over nothing; it is a separate port.
  - If a read and a write hit the same word in the same cycle, the read returns the old data.
- arlen=0: a single beat with rlast=1.
- Reset asserted mid-burst: rvalid drops immediately and the remaining beats are discarded.

Decomposition:
- Package axi_pkg holds:
  - resp constants: OKAY=2'b00, SLVERR=2'b10;
  - burst constants: FIXED=2'b00, INCR=2'b01, WRAP=2'b10;
  - the rd_state_e enum {IDLE, BURST, DRAIN}.
- Sub-module: icache_ram as the backing store, configured as a 1R1W synchronous RAM, width C_AXI_DATA_WIDTH, depth MEM_DEPTH.
- The skid buffer is kept inline.

Test Plan:
- Preload words 0..3 = k*0x11; INCR araddr=0x0, arlen=3, arid=0x2A, rready=1 -> 4 beats with data 0x00,0x11,0x22,0x33, rid=0x2A, OKAY, rlast only on beat 3; first rvalid at T+2, no bubbles.
- WRAP araddr=0x80 (word 2), arlen=3 -> words 2,3,0,1 in order, rlast on the 4th beat.
- Same INCR burst with rready toggling 1,0,0,1 randomly -> no beat lost or duplicated; data stays stable while stalled; arready=0 until the cycle after the last handshake.
- INCR starting at word MEM_DEPTH-2, arlen=3 -> OKAY, OKAY, SLVERR(0), SLVERR(0).
- arsize=3'd2 with arlen=1 -> 2 beats, both SLVERR, data 0, rlast on beat 1; arburst=FIXED behaves identically.
- Assert rst_n low at beat 2 of an 8-beat burst -> rvalid=0 immediately; after release arready=1 and a new burst returns correct data.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI response/burst encodings and the read-responder FSM state type.
package axi_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} rd_state_e;

endpackage

// File: rtl/axi_imem_rd_responder_if.sv
// AXI4 read-only bus (AR and R channels) between a requester and the imem responder.
interface axi_imem_rd_responder_if #(
    parameter int unsigned C_AXI_ID_WIDTH   = 10,
    parameter int unsigned C_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_AXI_DATA_WIDTH = 512
);
    logic                        arvalid;
    logic                        arready;
    logic [C_AXI_ID_WIDTH-1:0]   arid;
    logic [C_AXI_ADDR_WIDTH-1:0] araddr;
    logic [7:0]                  arlen;
    logic [2:0]                  arsize;
    logic [1:0]                  arburst;
    logic                        arlock;
    logic [3:0]                  arcache;
    logic [2:0]                  arprot;
    logic                        rvalid;
    logic                        rready;
    logic [C_AXI_ID_WIDTH-1:0]   rid;
    logic [C_AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                  rresp;
    logic                        rlast;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, rready,
        output arready, rvalid, rid, rdata, rresp, rlast
    );

endinterface

// File: rtl/icache_ram.sv
// 1R1W synchronous RAM; a read colliding with a write returns the old word.
module icache_ram #(
    parameter int unsigned WIDTH = 512,
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi_imem_rd_responder.sv
// AXI4 read responder serving full-width bursts from a preloadable line-wide RAM.
module axi_imem_rd_responder
    import axi_pkg::*;
#(
    parameter int unsigned               C_AXI_ID_WIDTH   = 10,
    parameter int unsigned               C_AXI_ADDR_WIDTH = 32,
    parameter int unsigned               C_AXI_DATA_WIDTH = 512,
    parameter int unsigned               MEM_DEPTH        = 1024,
    parameter logic [C_AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    axi_imem_rd_responder_if.slave       axi,
    input  logic                         ld_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] ld_addr,
    input  logic [C_AXI_DATA_WIDTH-1:0]  ld_data
);
    localparam int unsigned AW        = C_AXI_ADDR_WIDTH;
    localparam int unsigned DW        = C_AXI_DATA_WIDTH;
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
    localparam int unsigned SHIFT     = $clog2(DW / 8);
    localparam logic [2:0]  SIZE_FULL = 3'(SHIFT);

    rd_state_e                 state_q, state_d;
    logic [C_AXI_ID_WIDTH-1:0] id_q, id_d;
    logic [AW-1:0]             start_q, start_d;
    logic [7:0]                len_q, len_d, cnt_q, cnt_d;
    logic                      wrap_q, wrap_d, err_q, err_d;
    logic                      infl_q, infl_err_q, infl_last_q;
    logic                      infl_d, infl_err_d, infl_last_d;
    logic [1:0]                count_q, count_d;
    logic [DW-1:0]             head_data_q, head_data_d, skid_data_q, skid_data_d;
    logic [1:0]                head_resp_q, head_resp_d, skid_resp_q, skid_resp_d;
    logic                      head_last_q, head_last_d, skid_last_q, skid_last_d;

    logic          ar_fire, ar_err, wrap_len_ok, is_idle;
    logic [AW-1:0] ar_offset, ar_start, b_start, b_sum, b_mask, b_idx;
    logic [7:0]    b_cnt, b_len;
    logic          b_wrap, b_err, beat_err, beat_last;
    logic          pop, push, issue;
    logic [1:0]    occ;
    logic [DW-1:0] ram_rdata, push_data;
    logic          unused_ar;

    assign unused_ar = ^{axi.arlock, axi.arcache, axi.arprot};

    assign is_idle     = (state_q == IDLE);
    assign ar_fire     = axi.arvalid & axi.arready;
    assign ar_offset   = axi.araddr - BASE_ADDR;
    assign ar_start    = ar_offset >> SHIFT;
    assign wrap_len_ok = (axi.arlen == 8'd1) || (axi.arlen == 8'd3) ||
                         (axi.arlen == 8'd7) || (axi.arlen == 8'd15);
    assign ar_err      = (axi.araddr < BASE_ADDR) || (axi.arsize != SIZE_FULL) ||
                         (axi.arburst == FIXED) || (axi.arburst == 2'b11) ||
                         ((axi.arburst == WRAP) && !wrap_len_ok);

    // Beat 0 is issued straight off the AR handshake so first data lands two cycles later.
    assign b_start   = is_idle ? ar_start : start_q;
    assign b_cnt     = is_idle ? 8'd0 : cnt_q;
    assign b_len     = is_idle ? axi.arlen : len_q;
    assign b_wrap    = is_idle ? (axi.arburst == WRAP) : wrap_q;
    assign b_err     = is_idle ? ar_err : err_q;
    assign b_sum     = b_start + AW'(b_cnt);
    assign b_mask    = AW'(b_len);
    assign b_idx     = b_wrap ? ((b_start & ~b_mask) | (b_sum & b_mask)) : b_sum;
    assign beat_err  = b_err || (b_idx >= AW'(MEM_DEPTH));
    assign beat_last = (b_cnt == b_len);

    assign pop   = (count_q != 2'd0) & axi.rready;
    assign push  = infl_q;
    assign occ   = count_q + 2'(infl_q) - 2'(pop);
    assign issue = is_idle ? ar_fire : ((state_q == BURST) && (occ < 2'd2));

    assign push_data = infl_err_q ? '0 : ram_rdata;

    icache_ram #(
        .WIDTH (DW),
        .DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ld_we),
        .waddr (ld_addr),
        .wdata (ld_data),
        .re    (issue),
        .raddr (b_idx[IDX_W-1:0]),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        start_d     = start_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        wrap_d      = wrap_q;
        err_d       = err_q;
        infl_d      = issue;
        infl_err_d  = beat_err;
        infl_last_d = beat_last;
        unique case (state_q)
            IDLE: begin
                if (ar_fire) begin
                    id_d    = axi.arid;
                    start_d = ar_start;
                    len_d   = axi.arlen;
                    wrap_d  = (axi.arburst == WRAP);
                    err_d   = ar_err;
                    cnt_d   = 8'd1;
                    state_d = (axi.arlen == 8'd0) ? DRAIN : BURST;
                end
            end
            BURST: begin
                if (issue) begin
                    cnt_d = cnt_q + 8'd1;
                    if (beat_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_last_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-entry skid: head drives the R channel, skid catches a read landing during a stall.
    always_comb begin
        count_d     = count_q;
        head_data_d = head_data_q;
        head_resp_d = head_resp_q;
        head_last_d = head_last_q;
        skid_data_d = skid_data_q;
        skid_resp_d = skid_resp_q;
        skid_last_d = skid_last_q;
        case ({push, pop})
            2'b10: begin
                count_d = count_q + 2'd1;
                if (count_q == 2'd0) begin
                    head_data_d = push_data;
                    head_resp_d = infl_err_q ? SLVERR : OKAY;
                    head_last_d = infl_last_q;
                end else begin
                    skid_data_d = push_data;
                    skid_resp_d = infl_err_q ? SLVERR : OKAY;
                    skid_last_d = infl_last_q;
                end
            end
            2'b01: begin
                count_d     = count_q - 2'd1;
                head_data_d = skid_data_q;
                head_resp_d = skid_resp_q;
                head_last_d = skid_last_q;
            end
            2'b11: begin
                if (count_q == 2'd2) begin
                    head_data_d = skid_data_q;
                    head_resp_d = skid_resp_q;
                    head_last_d = skid_last_q;
                    skid_data_d = push_data;
                    skid_resp_d = infl_err_q ? SLVERR : OKAY;
                    skid_last_d = infl_last_q;
                end else begin
                    head_data_d = push_data;
                    head_resp_d = infl_err_q ? SLVERR : OKAY;
                    head_last_d = infl_last_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            id_q        <= '0;
            start_q     <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            wrap_q      <= 1'b0;
            err_q       <= 1'b0;
            infl_q      <= 1'b0;
            infl_err_q  <= 1'b0;
            infl_last_q <= 1'b0;
            count_q     <= '0;
            head_data_q <= '0;
            head_resp_q <= '0;
            head_last_q <= 1'b0;
            skid_data_q <= '0;
            skid_resp_q <= '0;
            skid_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            start_q     <= start_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            wrap_q      <= wrap_d;
            err_q       <= err_d;
            infl_q      <= infl_d;
            infl_err_q  <= infl_err_d;
            infl_last_q <= infl_last_d;
            count_q     <= count_d;
            head_data_q <= head_data_d;
            head_resp_q <= head_resp_d;
            head_last_q <= head_last_d;
            skid_data_q <= skid_data_d;
            skid_resp_q <= skid_resp_d;
            skid_last_q <= skid_last_d;
        end
    end

    assign axi.arready = rst_n & is_idle;
    assign axi.rvalid  = (count_q != 2'd0);
    assign axi.rdata   = head_data_q;
    assign axi.rresp   = head_resp_q;
    assign axi.rlast   = (count_q != 2'd0) & head_last_q;
    assign axi.rid     = id_q;

endmodule

// File: tb/tb_axi_imem_rd_responder.sv
// Directed bench for axi_imem_rd_responder: bursts, wrap, stalls, errors and mid-burst reset.
module tb_axi_imem_rd_responder;
    import axi_pkg::*;

    localparam int unsigned IDW   = 10;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 512;
    localparam int unsigned DEPTH = 1024;

    logic           clk;
    logic           rst_n;
    logic           ld_we;
    logic [9:0]     ld_addr;
    logic [DW-1:0]  ld_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0]  bd [16];
    logic [1:0]     br [16];
    logic           bl [16];
    logic [IDW-1:0] bid [16];
    int             bc [16];
    int             nb;

    axi_imem_rd_responder_if #(
        .C_AXI_ID_WIDTH   (IDW),
        .C_AXI_ADDR_WIDTH (AW),
        .C_AXI_DATA_WIDTH (DW)
    ) axi ();

    axi_imem_rd_responder #(
        .C_AXI_ID_WIDTH   (IDW),
        .C_AXI_ADDR_WIDTH (AW),
        .C_AXI_DATA_WIDTH (DW),
        .MEM_DEPTH        (DEPTH),
        .BASE_ADDR        (32'h0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .axi     (axi),
        .ld_we   (ld_we),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_we   = 1'b0;
    endtask

    task automatic send_ar(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        @(negedge clk);
        axi.arvalid = 1'b1;
        axi.arid    = id;
        axi.araddr  = addr;
        axi.arlen   = len;
        axi.arsize  = size;
        axi.arburst = burst;
        #1;
        chk("arready_at_ar", DW'(axi.arready), DW'(1));
    endtask

    // mode 0: rready held high; mode 1: rready 1,0,0,1 then random
    task automatic collect(input int nexp, input int mode);
        logic          stalled;
        logic [DW-1:0] held_d;
        logic          held_l;
        logic [3:0]    pat;
        int            cyc;
        pat     = 4'b1001;
        stalled = 1'b0;
        held_d  = '0;
        held_l  = 1'b0;
        nb      = 0;
        cyc     = 0;
        while (nb < nexp && cyc < 200) begin
            @(negedge clk);
            cyc++;
            axi.arvalid = 1'b0;
            if (mode == 0) axi.rready = 1'b1;
            else if (cyc >= 2 && cyc <= 5) axi.rready = pat[2'(cyc - 2)];
            else axi.rready = 1'($urandom_range(0, 1));
            #1;
            chk("arready_busy", DW'(axi.arready), DW'(0));
            if (stalled) begin
                chk("rvalid_hold", DW'(axi.rvalid), DW'(1));
                chk("rdata_hold", axi.rdata, held_d);
                chk("rlast_hold", DW'(axi.rlast), DW'(held_l));
            end
            if (axi.rvalid && axi.rready) begin
                bd[nb]  = axi.rdata;
                br[nb]  = axi.rresp;
                bl[nb]  = axi.rlast;
                bid[nb] = axi.rid;
                bc[nb]  = cyc;
                nb++;
                stalled = 1'b0;
            end else if (axi.rvalid) begin
                stalled = 1'b1;
                held_d  = axi.rdata;
                held_l  = axi.rlast;
            end
        end
        chk("beat_count", DW'(nb), DW'(nexp));
        @(negedge clk);
        axi.rready = 1'b0;
        #1;
        chk("arready_after", DW'(axi.arready), DW'(1));
        chk("rvalid_after", DW'(axi.rvalid), DW'(0));
    endtask

    task automatic expect_beat(input string t, input int k, input logic [DW-1:0] d,
                               input logic [1:0] r, input logic l, input logic [IDW-1:0] id);
        chk($sformatf("%s_data%0d", t, k), bd[k], d);
        chk($sformatf("%s_resp%0d", t, k), DW'(br[k]), DW'(r));
        chk($sformatf("%s_last%0d", t, k), DW'(bl[k]), DW'(l));
        chk($sformatf("%s_id%0d", t, k), DW'(bid[k]), DW'(id));
    endtask

    initial begin
        int            seen;
        logic [DW-1:0] w;
        rst_n       = 1'b0;
        ld_we       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        axi.arvalid = 1'b0;
        axi.arid    = '0;
        axi.araddr  = '0;
        axi.arlen   = '0;
        axi.arsize  = 3'd6;
        axi.arburst = INCR;
        axi.arlock  = 1'b0;
        axi.arcache = '0;
        axi.arprot  = '0;
        axi.rready  = 1'b0;
        #1;
        chk("rst_arready", DW'(axi.arready), DW'(0));
        chk("rst_rvalid", DW'(axi.rvalid), DW'(0));
        chk("rst_rlast", DW'(axi.rlast), DW'(0));
        chk("rst_rresp", DW'(axi.rresp), DW'(0));
        chk("rst_rid", DW'(axi.rid), DW'(0));
        chk("rst_rdata", axi.rdata, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_arready", DW'(axi.arready), DW'(1));

        for (int k = 0; k < 8; k++) preload(10'(k), DW'(k * 'h11));
        preload(10'd1022, DW'('hAA));
        preload(10'd1023, DW'('hBB));

        // INCR, 4 beats, back-to-back from T+2
        send_ar(10'h2A, 32'h0, 8'd3, 3'd6, INCR);
        collect(4, 0);
        for (int k = 0; k < 4; k++) begin
            expect_beat("incr", k, DW'(k * 'h11), OKAY, (k == 3), 10'h2A);
            chk($sformatf("incr_cycle%0d", k), DW'(bc[k]), DW'(2 + k));
        end

        // WRAP from word 2: 2,3,0,1
        send_ar(10'h15, 32'h80, 8'd3, 3'd6, WRAP);
        collect(4, 0);
        expect_beat("wrap", 0, DW'('h22), OKAY, 1'b0, 10'h15);
        expect_beat("wrap", 1, DW'('h33), OKAY, 1'b0, 10'h15);
        expect_beat("wrap", 2, DW'('h00), OKAY, 1'b0, 10'h15);
        expect_beat("wrap", 3, DW'('h11), OKAY, 1'b1, 10'h15);

        // INCR with rready stalls
        send_ar(10'h2A, 32'h0, 8'd3, 3'd6, INCR);
        collect(4, 1);
        for (int k = 0; k < 4; k++) expect_beat("stall", k, DW'(k * 'h11), OKAY, (k == 3), 10'h2A);

        // Runs off the end of the RAM
        send_ar(10'h3, 32'hFF80, 8'd3, 3'd6, INCR);
        collect(4, 0);
        expect_beat("range", 0, DW'('hAA), OKAY, 1'b0, 10'h3);
        expect_beat("range", 1, DW'('hBB), OKAY, 1'b0, 10'h3);
        expect_beat("range", 2, '0, SLVERR, 1'b0, 10'h3);
        expect_beat("range", 3, '0, SLVERR, 1'b1, 10'h3);

        send_ar(10'h4, 32'h0, 8'd1, 3'd2, INCR);
        collect(2, 0);
        expect_beat("size", 0, '0, SLVERR, 1'b0, 10'h4);
        expect_beat("size", 1, '0, SLVERR, 1'b1, 10'h4);

        send_ar(10'h5, 32'h0, 8'd1, 3'd6, FIXED);
        collect(2, 0);
        expect_beat("fixed", 0, '0, SLVERR, 1'b0, 10'h5);
        expect_beat("fixed", 1, '0, SLVERR, 1'b1, 10'h5);

        send_ar(10'h6, 32'h0, 8'd2, 3'd6, WRAP);
        collect(3, 0);
        for (int k = 0; k < 3; k++) expect_beat("badwrap", k, '0, SLVERR, (k == 2), 10'h6);

        // Single beat, unaligned address truncates to word 1
        send_ar(10'h7, 32'h47, 8'd0, 3'd6, INCR);
        collect(1, 0);
        expect_beat("single", 0, DW'('h11), OKAY, 1'b1, 10'h7);

        // Reset while beat 2 of an 8-beat burst is on the bus
        send_ar(10'h9, 32'h0, 8'd7, 3'd6, INCR);
        seen = 0;
        for (int c = 0; c < 20 && seen < 3; c++) begin
            @(negedge clk);
            axi.arvalid = 1'b0;
            axi.rready  = 1'b1;
            #1;
            if (axi.rvalid) seen++;
        end
        chk("mid_reached_beat2", DW'(seen), DW'(3));
        w = axi.rdata;
        chk("mid_beat2_data", w, DW'('h22));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", DW'(axi.rvalid), DW'(0));
        chk("mid_rst_rlast", DW'(axi.rlast), DW'(0));
        chk("mid_rst_arready", DW'(axi.arready), DW'(0));
        chk("mid_rst_rid", DW'(axi.rid), DW'(0));
        chk("mid_rst_rdata", axi.rdata, '0);
        axi.rready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_post_arready", DW'(axi.arready), DW'(1));
        chk("mid_post_rvalid", DW'(axi.rvalid), DW'(0));
        send_ar(10'h1F, 32'h40, 8'd1, 3'd6, INCR);
        collect(2, 0);
        expect_beat("after_rst", 0, DW'('h11), OKAY, 1'b0, 10'h1F);
        expect_beat("after_rst", 1, DW'('h22), OKAY, 1'b1, 10'h1F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
